store_unit: RTL and testbench

//  Store execution stage directly downstream of the store decoder. It takes STOREop and the

---
 rtl/store_unit.sv | 127 ++++++++++++
 tb/tb_store_unit.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_unit.sv
// store_unit: store execution stage between the control FSM and the memory/MMU port.
//   Accepts one store request, builds byte strobes and lane-replicated write data,
//   runs a valid/ready handshake with an optional timeout, and reports the outcome as a
//   single pulse: done, misaligned trap or access fault. Misaligned stores never reach the bus.
// Ports:
//   i_clk, i_reset          clock (rising edge), synchronous active-high reset
//   i_start                 one-cycle request pulse, honoured only when idle
//   i_storeop               store op from the decoder (SB/SH/SW, other codes write no bytes)
//   i_is_store_unaligned    misaligned flag from the decoder
//   i_addr, i_wdata_in      effective address and unshifted rs2 value
//   o_mem_valid, i_mem_ready, o_mem_addr, o_mem_wdata, o_mem_wstrb   bus request
//   o_busy                  high whenever not idle
//   o_done, o_trap_misaligned, o_trap_access_fault   one-cycle outcome pulses
//   o_trap_addr             original address of the last accepted request, for mtval
module store_unit #(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int ADDR_WIDTH     = 32,
    parameter int STORE_OP_WIDTH = 2
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_start,
    input  logic [STORE_OP_WIDTH-1:0] i_storeop,
    input  logic                      i_is_store_unaligned,
    input  logic [ADDR_WIDTH-1:0]     i_addr,
    input  logic [31:0]               i_wdata_in,
    output logic                      o_mem_valid,
    input  logic                      i_mem_ready,
    output logic [ADDR_WIDTH-1:0]     o_mem_addr,
    output logic [31:0]               o_mem_wdata,
    output logic [3:0]                o_mem_wstrb,
    output logic                      o_busy,
    output logic                      o_done,
    output logic                      o_trap_misaligned,
    output logic                      o_trap_access_fault,
    output logic [ADDR_WIDTH-1:0]     o_trap_addr
);
    localparam logic [STORE_OP_WIDTH-1:0] OP_SB = STORE_OP_WIDTH'(0);
    localparam logic [STORE_OP_WIDTH-1:0] OP_SH = STORE_OP_WIDTH'(1);
    localparam logic [STORE_OP_WIDTH-1:0] OP_SW = STORE_OP_WIDTH'(2);
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_DONE, S_TRAP, S_FAULT} state_t;

    state_t                r_state;
    logic [31:0]           r_cnt;
    logic                  r_mem_valid;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [31:0]           r_mem_wdata;
    logic [3:0]            r_mem_wstrb;
    logic                  r_done;
    logic                  r_trap_mis;
    logic                  r_trap_fault;
    logic [ADDR_WIDTH-1:0] r_trap_addr;
    logic [1:0]            w_off;
    logic [3:0]            w_wstrb;
    logic [31:0]           w_wdata;

    assign w_off = i_addr[1:0];

    // Lane data is replicated rather than shifted, so the strobes alone select the bytes.
    always_comb begin
        w_wstrb = (i_storeop == OP_SB) ? 4'b0001 << w_off :
                  (i_storeop == OP_SH) ? 4'b0011 << w_off :
                  (i_storeop == OP_SW) ? 4'b1111 : 4'b0000;
        w_wdata = (i_storeop == OP_SH) ? {2{i_wdata_in[15:0]}} :
                  (i_storeop == OP_SW) ? i_wdata_in : {4{i_wdata_in[7:0]}};
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_mem_valid  <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_wstrb  <= '0;
            r_done       <= 1'b0;
            r_trap_mis   <= 1'b0;
            r_trap_fault <= 1'b0;
            r_trap_addr  <= '0;
        end else begin
            r_done       <= 1'b0;
            r_trap_mis   <= 1'b0;
            r_trap_fault <= 1'b0;
            case (r_state)
                S_IDLE: if (i_start) begin
                    r_trap_addr <= i_addr;
                    r_mem_addr  <= {i_addr[ADDR_WIDTH-1:2], 2'b00};
                    r_mem_wdata <= w_wdata;
                    r_mem_wstrb <= w_wstrb;
                    r_cnt       <= '0;
                    if (i_is_store_unaligned) begin
                        r_state    <= S_TRAP;
                        r_trap_mis <= 1'b1;
                    end else begin
                        r_state     <= S_REQ;
                        r_mem_valid <= 1'b1;
                    end
                end
                // Ready is tested first so it beats a timeout on the same cycle.
                S_REQ: if (i_mem_ready) begin
                    r_state     <= S_DONE;
                    r_done      <= 1'b1;
                    r_mem_valid <= 1'b0;
                end else if (TIMEOUT_CYCLES != 0 && r_cnt == TO_LAST) begin
                    r_state      <= S_FAULT;
                    r_trap_fault <= 1'b1;
                    r_mem_valid  <= 1'b0;
                end else begin
                    r_cnt <= r_cnt + 32'd1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_mem_valid         = r_mem_valid;
    assign o_mem_addr          = r_mem_addr;
    assign o_mem_wdata         = r_mem_wdata;
    assign o_mem_wstrb         = r_mem_wstrb;
    assign o_busy              = (r_state != S_IDLE);
    assign o_done              = r_done;
    assign o_trap_misaligned   = r_trap_mis;
    assign o_trap_access_fault = r_trap_fault;
    assign o_trap_addr         = r_trap_addr;
endmodule

// File: tb/tb_store_unit.sv
// tb_store_unit: randomized self-checking bench for store_unit against a byte-lane model.
module tb_store_unit;
    localparam logic [1:0] SB = 2'd0, SH = 2'd1, SW = 2'd2;

    logic clk = 0, reset = 1, start = 0, s4 = 0, unal = 0, rdy = 0, rdy4 = 0;
    logic [1:0]  op = 0;
    logic [31:0] addr = 0, data = 0;
    logic        mv, busy, done, tm, tf, mv4, busy4, done4, tm4, tf4;
    logic [31:0] ma, mw, ta, ma4, mw4, ta4;
    logic [3:0]  ms, ms4;
    int checks = 0, errors = 0;

    store_unit dut (
        .i_clk(clk), .i_reset(reset), .i_start(start), .i_storeop(op),
        .i_is_store_unaligned(unal), .i_addr(addr), .i_wdata_in(data),
        .o_mem_valid(mv), .i_mem_ready(rdy), .o_mem_addr(ma), .o_mem_wdata(mw),
        .o_mem_wstrb(ms), .o_busy(busy), .o_done(done), .o_trap_misaligned(tm),
        .o_trap_access_fault(tf), .o_trap_addr(ta)
    );

    store_unit #(.TIMEOUT_CYCLES(4)) dut4 (
        .i_clk(clk), .i_reset(reset), .i_start(s4), .i_storeop(op),
        .i_is_store_unaligned(unal), .i_addr(addr), .i_wdata_in(data),
        .o_mem_valid(mv4), .i_mem_ready(rdy4), .o_mem_addr(ma4), .o_mem_wdata(mw4),
        .o_mem_wstrb(ms4), .o_busy(busy4), .o_done(done4), .o_trap_misaligned(tm4),
        .o_trap_access_fault(tf4), .o_trap_addr(ta4)
    );

    always #5 clk = ~clk;

    function automatic int op_bytes(input logic [1:0] o_p);
        return (o_p == SB) ? 1 : (o_p == SH) ? 2 : (o_p == SW) ? 4 : 0;
    endfunction

    function automatic logic [3:0] m_strb(input logic [1:0] o_p, input logic [1:0] off);
        int n = op_bytes(o_p);
        int o = int'(off);
        for (int i = 0; i < 4; i++) m_strb[i] = (i >= o) && (i < o + n);
    endfunction

    function automatic logic [31:0] m_data(input logic [1:0] o_p, input logic [31:0] d);
        int n = (op_bytes(o_p) == 0) ? 1 : op_bytes(o_p);
        for (int i = 0; i < 4; i++) m_data[8*i +: 8] = d[8*(i % n) +: 8];
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1;
        step;
        step;
        checks++;
        if ({mv, ma, mw, ms} !== '0) begin
            errors++;
            $display("FAIL reset_bus: valid=%b addr=%h wdata=%h wstrb=%b, want all 0", mv, ma, mw, ms);
        end
        checks++;
        if ({busy, done, tm, tf} !== 4'b0) begin
            errors++;
            $display("FAIL reset_status: busy=%b done=%b tm=%b tf=%b, want 0", busy, done, tm, tf);
        end
        checks++;
        if (ta !== 32'h0 || mv4 !== 1'b0 || busy4 !== 1'b0) begin
            errors++;
            $display("FAIL reset_misc: trap_addr=%h valid4=%b busy4=%b, want 0", ta, mv4, busy4);
        end
        reset = 0;
        step;
    endtask

    task automatic test_lanes;
        logic [1:0]  o_p;
        logic [31:0] a, d;
        int dly;
        for (int t = 0; t < 40; t++) begin
            o_p = 2'($urandom_range(0, 3));
            a = $urandom;
            d = $urandom;
            dly = $urandom_range(0, 3);
            if (o_p == SH) a[0] = 1'b0;
            if (o_p == SW) a[1:0] = 2'b00;
            if (t == 0) begin o_p = SB; a = 32'h1003; d = 32'hA5; dly = 0; end
            if (t == 1) begin o_p = SH; a = 32'h2002; d = 32'h1234BEEF; dly = 0; end
            if (t == 2) begin o_p = SW; a = 32'h2000; dly = 0; end
            if (t == 3) begin o_p = SW; a = 32'h2400; dly = 5; end
            op = o_p; addr = a; data = d; unal = 0; start = 1;
            step;
            start = 0; op = 2'($urandom_range(0, 3)); addr = $urandom; data = $urandom;
            for (int k = 0; k <= dly; k++) begin
                checks++;
                if (mv !== 1'b1 || busy !== 1'b1 || ma !== {a[31:2], 2'b00} ||
                    mw !== m_data(o_p, d) || ms !== m_strb(o_p, a[1:0])) begin
                    errors++;
                    $display("FAIL lanes t=%0d k=%0d: valid=%b busy=%b addr=%h wdata=%h wstrb=%b, want 1 1 %h %h %b",
                             t, k, mv, busy, ma, mw, ms, {a[31:2], 2'b00}, m_data(o_p, d), m_strb(o_p, a[1:0]));
                end
                rdy = (k == dly);
                step;
            end
            rdy = 0;
            checks++;
            if (done !== 1'b1 || mv !== 1'b0 || tm !== 1'b0 || tf !== 1'b0) begin
                errors++;
                $display("FAIL lanes_done t=%0d: done=%b valid=%b tm=%b tf=%b, want 1 0 0 0", t, done, mv, tm, tf);
            end
            step;
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL lanes_idle t=%0d: done=%b busy=%b, want 0 0", t, done, busy);
            end
        end
    endtask

    task automatic test_misaligned;
        logic [31:0] a;
        for (int t = 0; t < 8; t++) begin
            a = $urandom;
            a[0] = 1'b1;
            op = (t == 0 || a[4]) ? SW : SH;
            if (t == 0) a = 32'h3001;
            addr = a; data = $urandom; unal = 1; start = 1;
            step;
            start = 0; unal = 0;
            checks++;
            if (tm !== 1'b1 || ta !== a || mv !== 1'b0 || done !== 1'b0 || tf !== 1'b0) begin
                errors++;
                $display("FAIL misaligned t=%0d: trap=%b trap_addr=%h valid=%b done=%b tf=%b, want 1 %h 0 0 0",
                         t, tm, ta, mv, done, tf, a);
            end
            step;
            checks++;
            if (tm !== 1'b0 || mv !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL misaligned_end t=%0d: trap=%b valid=%b busy=%b, want 0 0 0", t, tm, mv, busy);
            end
        end
    endtask

    task automatic test_timeout;
        int nv, nd, nf;
        for (int c = 0; c < 2; c++) begin
            op = SW; addr = 32'h4000; data = $urandom; unal = 0; s4 = 1;
            step;
            s4 = 0;
            nv = 0; nd = 0; nf = 0;
            for (int k = 0; k < 12; k++) begin
                nv += int'(mv4); nd += int'(done4); nf += int'(tf4);
                rdy4 = (c == 1) && mv4 && (nv == 4);
                step;
            end
            rdy4 = 0;
            checks++;
            if (nv != 4) begin
                errors++;
                $display("FAIL timeout_valid c=%0d: valid cycles=%0d, want 4", c, nv);
            end
            checks++;
            if (nd != c) begin
                errors++;
                $display("FAIL timeout_done c=%0d: done pulses=%0d, want %0d", c, nd, c);
            end
            checks++;
            if (nf != 1 - c) begin
                errors++;
                $display("FAIL timeout_fault c=%0d: fault pulses=%0d, want %0d", c, nf, 1 - c);
            end
        end
    endtask

    task automatic test_reset_mid;
        int nv, np;
        op = SW; addr = 32'h5000; data = $urandom; unal = 0; start = 1;
        step;
        addr = 32'h6004;
        step;
        start = 0;
        checks++;
        if (mv !== 1'b1 || ma !== 32'h5000) begin
            errors++;
            $display("FAIL busy_start: valid=%b addr=%h, want 1 00005000", mv, ma);
        end
        reset = 1;
        step;
        reset = 0;
        checks++;
        if ({mv, ma, mw, ms, busy, done, tm, tf, ta} !== '0) begin
            errors++;
            $display("FAIL reset_mid: valid=%b addr=%h wdata=%h wstrb=%b busy=%b ta=%h, want all 0", mv, ma, mw, ms, busy, ta);
        end
        nv = 0; np = 0;
        for (int k = 0; k < 6; k++) begin
            nv += int'(mv); np += int'(done) + int'(tm) + int'(tf);
            step;
        end
        checks++;
        if (nv != 0 || np != 0) begin
            errors++;
            $display("FAIL reset_after: valid cycles=%0d pulses=%0d, want 0 0", nv, np);
        end
    endtask

    task automatic test_back_to_back;
        op = SB; addr = 32'h7001; data = 32'h5A; unal = 0; start = 1;
        step;
        start = 0; rdy = 1;
        checks++;
        if (mv !== 1'b1 || ms !== 4'b0010) begin
            errors++;
            $display("FAIL b2b_req: valid=%b wstrb=%b, want 1 0010", mv, ms);
        end
        step;
        start = 1; addr = 32'h8000;
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL b2b_done: done=%b, want 1", done);
        end
        step;
        start = 0;
        checks++;
        if (busy !== 1'b0 || mv !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_ignored: busy=%b valid=%b done=%b, want 0 0 0", busy, mv, done);
        end
        step;
        checks++;
        if (done !== 1'b0 || mv !== 1'b0) begin
            errors++;
            $display("FAIL idle_ready: done=%b valid=%b, want 0 0", done, mv);
        end
        rdy = 0; op = SW; addr = 32'h9000; start = 1;
        step;
        start = 0;
        checks++;
        if (mv !== 1'b1 || ma !== 32'h9000) begin
            errors++;
            $display("FAIL b2b_second: valid=%b addr=%h, want 1 00009000", mv, ma);
        end
        rdy = 1;
        step;
        rdy = 0;
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second_done: done=%b, want 1", done);
        end
        step;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_lanes;
        test_misaligned;
        test_timeout;
        test_reset_mid;
        test_back_to_back;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
